// File: rtl/tiny_proc_pkg.sv
// Shared command codes, frame geometry and FSM encoding for the tiny processor
// serial load port.
package tiny_proc_pkg;

    localparam int unsigned FRAME_W   = 12;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = 4;

    localparam logic [1:0] CMD_WR_I = 2'b00;
    localparam logic [1:0] CMD_WR_D = 2'b01;
    localparam logic [1:0] CMD_RUN  = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    // On-wire frame layout; bit 0 (addr LSB) goes out first.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } frame_t;

endpackage

// File: rtl/spi_frame_shifter.sv
// Frame-wide PISO for mosi plus SIPO for miso, both shifting right.
module spi_frame_shifter
    import tiny_proc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_word,
    input  logic               shift_en,
    input  logic               rx_bit,
    output logic               tx_bit,
    output logic [FRAME_W-1:0] rx_word
);

    logic [FRAME_W-1:0] tx_q;
    logic [FRAME_W-2:0] rx_q;

    // tx fills with zeros so mosi idles low once the frame has gone out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
            rx_q <= '0;
        end else if (load) begin
            tx_q <= load_word;
            rx_q <= '0;
        end else if (shift_en) begin
            tx_q <= {1'b0, tx_q[FRAME_W-1:1]};
            rx_q <= {rx_bit, rx_q[FRAME_W-2:1]};
        end
    end

    assign tx_bit  = tx_q[0];
    // Includes the bit on rx_bit now, so the word is complete on the last shift edge.
    assign rx_word = {rx_bit, rx_q};

endmodule

// File: rtl/spi_prog_master.sv
// Host-side serial load master: frames WR_I/WR_D commands onto mosi under
// csi_n/csd_n, captures miso full-duplex, and gates proc_en for RUN/STOP.
module spi_prog_master
    import tiny_proc_pkg::*;
#(
    parameter int unsigned GAP_CYC   = 2,
    parameter int unsigned RUN_CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_data,
    output logic               csi_n,
    output logic               csd_n,
    output logic               mosi,
    input  logic               miso,
    output logic               proc_en,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    output logic               done,
    output logic               busy
);

    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    logic [1:0]           state_q,   state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic                 is_data_q, is_data_d;
    logic                 csi_n_d, csd_n_d, proc_en_d, rx_valid_d, done_d, busy_d;
    logic [FRAME_W-1:0]   rx_data_d;

    logic               accept;
    logic               load;
    logic               shift_en;
    logic [FRAME_W-1:0] rx_word;
    frame_t             frame;

    assign frame     = '{data: cmd_data, addr: cmd_addr};
    assign cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_RUN) && (cmd_type == CMD_STOP));
    assign accept    = cmd_valid & cmd_ready;

    spi_frame_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_word (frame),
        .shift_en  (shift_en),
        .rx_bit    (miso),
        .tx_bit    (mosi),
        .rx_word   (rx_word)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        run_cnt_d  = run_cnt_q;
        is_data_d  = is_data_q;
        rx_data_d  = rx_data;
        proc_en_d  = 1'b0;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        load       = 1'b0;
        shift_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_type)
                        CMD_WR_I, CMD_WR_D: begin
                            load      = 1'b1;
                            state_d   = ST_SHIFT;
                            bit_cnt_d = '0;
                            is_data_d = (cmd_type == CMD_WR_D);
                        end
                        CMD_RUN: begin
                            state_d   = ST_RUN;
                            run_cnt_d = RUN_CNT_W'(cmd_data);
                            proc_en_d = 1'b1;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt_q == BIT_CNT_W'(FRAME_W - 1)) begin
                    state_d    = ST_GAP;
                    gap_cnt_d  = '0;
                    rx_data_d  = rx_word;
                    rx_valid_d = 1'b1;
                    done_d     = (GAP_CYC == 1);
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    done_d    = (gap_cnt_d == GAP_W'(GAP_CYC - 1));
                end
            end
            ST_RUN: begin
                proc_en_d = 1'b1;
                // A zero count never reaches 1, so it runs until STOP.
                if (accept || (run_cnt_q == RUN_CNT_W'(1))) begin
                    state_d   = ST_IDLE;
                    proc_en_d = 1'b0;
                    done_d    = 1'b1;
                end else if (run_cnt_q != '0) begin
                    run_cnt_d = run_cnt_q - RUN_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        csi_n_d = !((state_d == ST_SHIFT) && !is_data_d);
        csd_n_d = !((state_d == ST_SHIFT) &&  is_data_d);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            run_cnt_q <= '0;
            is_data_q <= 1'b0;
            csi_n     <= 1'b1;
            csd_n     <= 1'b1;
            proc_en   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            run_cnt_q <= run_cnt_d;
            is_data_q <= is_data_d;
            csi_n     <= csi_n_d;
            csd_n     <= csd_n_d;
            proc_en   <= proc_en_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            done      <= done_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_prog_master.sv
// Directed bench for spi_prog_master: a time-since-accept reference model is
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_spi_prog_master;
    import tiny_proc_pkg::*;

    localparam int GAP = 2;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        csi_n, csd_n, mosi, miso, proc_en, rx_valid, done, busy;
    logic [11:0] rx_data;

    int n_tests = 0;
    int n_fail  = 0;

    spi_prog_master #(.GAP_CYC(GAP), .RUN_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .csi_n     (csi_n),
        .csd_n     (csd_n),
        .mosi      (mosi),
        .miso      (miso),
        .proc_en   (proc_en),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: m_t counts clock edges since the accepting edge.
    localparam int M_IDLE = 0, M_FRAME = 1, M_RUN = 2;
    int          m_mode, m_t, m_len;
    logic [11:0] m_word, m_rx_acc, m_rx_data;
    logic        m_isd, m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode    <= M_IDLE;
            m_t       <= 0;
            m_len     <= 0;
            m_word    <= '0;
            m_rx_acc  <= '0;
            m_rx_data <= '0;
            m_isd     <= 1'b0;
            m_done    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            case (m_mode)
                M_IDLE: if (cmd_valid) begin
                    if (cmd_type == CMD_WR_I || cmd_type == CMD_WR_D) begin
                        m_mode <= M_FRAME;
                        m_t    <= 0;
                        m_word <= {cmd_data, cmd_addr};
                        m_isd  <= (cmd_type == CMD_WR_D);
                    end else if (cmd_type == CMD_RUN) begin
                        m_mode <= M_RUN;
                        m_t    <= 0;
                        m_len  <= 32'(cmd_data);
                    end else begin
                        m_done <= 1'b1;
                    end
                end
                M_FRAME: begin
                    if (m_t < 12) m_rx_acc[4'(m_t)] <= miso;
                    if (m_t == 11) m_rx_data <= {miso, m_rx_acc[10:0]};
                    if (m_t == 11 + GAP) m_mode <= M_IDLE;
                    else m_t <= m_t + 1;
                end
                M_RUN: begin
                    if ((cmd_valid && cmd_type == CMD_STOP) || (m_len != 0 && m_t == m_len - 1)) begin
                        m_mode <= M_IDLE;
                        m_done <= 1'b1;
                    end else begin
                        m_t <= m_t + 1;
                    end
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    logic e_shift, e_csi_n, e_csd_n, e_mosi, e_rx_valid, e_done, e_proc_en, e_busy, e_ready;

    always_comb begin
        e_shift    = (m_mode == M_FRAME) && (m_t < 12);
        e_csi_n    = !(e_shift && !m_isd);
        e_csd_n    = !(e_shift && m_isd);
        e_mosi     = e_shift ? m_word[4'(m_t)] : 1'b0;
        e_rx_valid = (m_mode == M_FRAME) && (m_t == 12);
        e_done     = m_done || ((m_mode == M_FRAME) && (m_t == 11 + GAP));
        e_proc_en  = (m_mode == M_RUN);
        e_busy     = (m_mode != M_IDLE);
        e_ready    = (m_mode == M_IDLE) || ((m_mode == M_RUN) && (cmd_type == CMD_STOP));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
        chk("csi_n",     32'(csi_n),     32'(e_csi_n));
        chk("csd_n",     32'(csd_n),     32'(e_csd_n));
        chk("mosi",      32'(mosi),      32'(e_mosi));
        chk("proc_en",   32'(proc_en),   32'(e_proc_en));
        chk("rx_data",   32'(rx_data),   32'(m_rx_data));
        chk("rx_valid",  32'(rx_valid),  32'(e_rx_valid));
        chk("done",      32'(done),      32'(e_done));
        chk("busy",      32'(busy),      32'(e_busy));
    endtask

    task automatic tick_neg();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick_pos();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [1:0] typ, input logic [3:0] a, input logic [7:0] d);
        bit acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_type  = typ;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 100 && !acc; i++) begin
            tick_neg();
            acc = e_ready;
            tick_pos();
        end
        cmd_valid = 1'b0;
        chk("accepted", 32'(acc), 1);
    endtask

    task automatic run_frame(input logic [1:0] typ, input logic [3:0] a, input logic [7:0] d,
                             input logic [11:0] pat, output int ci, output int cd,
                             output logic [11:0] bits, output int done_at, output int rxv,
                             output logic [11:0] rxw);
        issue(typ, a, d);
        ci = 0; cd = 0; bits = '0; done_at = -1; rxv = 0; rxw = '0;
        miso = pat[0];
        for (int c = 1; c <= 18; c++) begin
            tick_neg();
            if (!csi_n) ci++;
            if (!csd_n) cd++;
            if ((!csi_n || !csd_n) && (ci + cd) <= 12) bits[4'(ci + cd - 1)] = mosi;
            if (rx_valid) begin
                rxv++;
                rxw = rx_data;
            end
            if (done && done_at < 0) done_at = c;
            tick_pos();
            miso = (c < 12) ? pat[4'(c)] : 1'b0;
        end
    endtask

    int          ci, cd, done_at, rxv, pe, rdy_low, last_pe;
    logic [11:0] bits, rxw;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = 2'b00;
        cmd_addr = 4'h0; cmd_data = 8'h00; miso = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tick_neg();
        chk("rst_csi_n", 32'(csi_n), 1);
        chk("rst_csd_n", 32'(csd_n), 1);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_proc_en", 32'(proc_en), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        tick_pos();
        rst_n = 1'b1;
        tick_neg(); tick_pos();

        // WR_I addr 3 data A5
        run_frame(CMD_WR_I, 4'd3, 8'hA5, 12'h000, ci, cd, bits, done_at, rxv, rxw);
        chk("t1_csi_cycles", ci, 12);
        chk("t1_csd_cycles", cd, 0);
        chk("t1_mosi_bits", 32'(bits), 32'h0A53);
        chk("t1_rx_valid_count", rxv, 1);

        // WR_D addr 15 data 80
        run_frame(CMD_WR_D, 4'd15, 8'h80, 12'h000, ci, cd, bits, done_at, rxv, rxw);
        chk("t2_csi_cycles", ci, 0);
        chk("t2_csd_cycles", cd, 12);
        chk("t2_last_bit", 32'(bits[11]), 1);
        chk("t2_mosi_bits", 32'(bits), 32'h080F);
        chk("t2_done_latency", done_at, 14);

        // miso pattern capture
        run_frame(CMD_WR_I, 4'd0, 8'h00, 12'h5C3, ci, cd, bits, done_at, rxv, rxw);
        chk("t3_rx_valid_count", rxv, 1);
        chk("t3_rx_data", 32'(rxw), 32'h05C3);

        // RUN for 5 cycles
        issue(CMD_RUN, 4'd0, 8'd5);
        pe = 0; rdy_low = 0; done_at = -1; last_pe = -1;
        for (int c = 1; c <= 10; c++) begin
            tick_neg();
            if (proc_en) begin
                pe++;
                last_pe = c;
                if (!cmd_ready) rdy_low++;
            end
            if (done && done_at < 0) done_at = c;
            tick_pos();
        end
        chk("t4_proc_en_cycles", pe, 5);
        chk("t4_ready_low_cycles", rdy_low, 5);
        chk("t4_last_proc_en", last_pe, 5);
        chk("t4_done_cycle", done_at, 6);

        // STOP while idle
        issue(CMD_STOP, 4'd0, 8'd0);
        tick_neg();
        chk("stop_idle_done", 32'(done), 1);
        chk("stop_idle_busy", 32'(busy), 0);
        tick_pos();
        tick_neg();
        chk("stop_idle_done_once", 32'(done), 0);
        tick_pos();

        // RUN until STOP, WR_I held off meanwhile
        issue(CMD_RUN, 4'd0, 8'd0);
        cmd_valid = 1'b1; cmd_type = CMD_WR_I; cmd_addr = 4'd1; cmd_data = 8'h11;
        pe = 0; rdy_low = 0;
        for (int c = 1; c <= 40; c++) begin
            tick_neg();
            if (proc_en) pe++;
            if (!cmd_ready) rdy_low++;
            tick_pos();
        end
        chk("t5_proc_en_cycles", pe, 40);
        chk("t5_wr_held_off", rdy_low, 40);
        cmd_type = CMD_STOP;
        tick_neg();
        chk("t5_stop_ready", 32'(cmd_ready), 1);
        tick_pos();
        cmd_valid = 1'b0;
        tick_neg();
        chk("t5_proc_en_off", 32'(proc_en), 0);
        chk("t5_done", 32'(done), 1);
        tick_pos();
        run_frame(CMD_WR_I, 4'd1, 8'h11, 12'h000, ci, cd, bits, done_at, rxv, rxw);
        chk("t5_wr_after_bits", 32'(bits), 32'h0111);

        // Reset during SHIFT bit 6
        issue(CMD_WR_I, 4'd3, 8'hA5);
        for (int c = 1; c <= 7; c++) begin
            tick_neg();
            if (c < 7) tick_pos();
        end
        chk("t6_cs_low_before_rst", 32'(csi_n), 0);
        chk("t6_bit6", 32'(mosi), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_csi_n", 32'(csi_n), 1);
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_mosi", 32'(mosi), 0);
        tick_pos();
        tick_neg(); tick_pos();
        rst_n = 1'b1;
        rxv = 0; done_at = 0;
        for (int c = 1; c <= 20; c++) begin
            tick_neg();
            if (rx_valid) rxv++;
            if (done) done_at++;
            tick_pos();
        end
        chk("t6_no_rx_valid", rxv, 0);
        chk("t6_no_done", done_at, 0);
        run_frame(CMD_WR_I, 4'd9, 8'h3C, 12'hA5A, ci, cd, bits, done_at, rxv, rxw);
        chk("t6_next_frame_bits", 32'(bits), 32'h03C9);
        chk("t6_next_frame_cs", ci, 12);
        chk("t6_next_frame_rx", 32'(rxw), 32'h0A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
